// File: rtl/udp_port_demux.sv
// udp_port_demux: steers decoded UDP frames by destination port
// to CHANNELS AXI-Stream payload outputs and keeps per-channel stats.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   chan_enable       per-channel enable, sampled at header accept
//   s_udp_hdr_*       header handshake and sender/dest fields
//   s_udp_payload_*   upstream payload AXI-Stream
//   m_t*              per-channel payload AXI-Stream (slice i = ch i)
//   peer_*            last good sender endpoint per channel
//   frame_count       good frames delivered per channel
//   bad_count         tuser=1 frames delivered per channel
//   drop_count        frames discarded (unmatched or disabled)
module udp_port_demux #(
   parameter int          CHANNELS   = 4,
   parameter int          DATA_WIDTH = 8,
   parameter int          KEEP_WIDTH = DATA_WIDTH/8,
   parameter logic [15:0] BASE_PORT  = 16'd1234,
   parameter int          CNT_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CHANNELS-1:0]            chan_enable,
   input  logic                           s_udp_hdr_valid,
   output logic                           s_udp_hdr_ready,
   input  logic [31:0]                    s_udp_ip_source_ip,
   input  logic [15:0]                    s_udp_source_port,
   input  logic [15:0]                    s_udp_dest_port,
   input  logic [DATA_WIDTH-1:0]          s_udp_payload_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]          s_udp_payload_axis_tkeep,
   input  logic                           s_udp_payload_axis_tvalid,
   output logic                           s_udp_payload_axis_tready,
   input  logic                           s_udp_payload_axis_tlast,
   input  logic                           s_udp_payload_axis_tuser,
   output logic [CHANNELS*DATA_WIDTH-1:0] m_tdata,
   output logic [CHANNELS*KEEP_WIDTH-1:0] m_tkeep,
   output logic [CHANNELS-1:0]            m_tvalid,
   input  logic [CHANNELS-1:0]            m_tready,
   output logic [CHANNELS-1:0]            m_tlast,
   output logic [CHANNELS-1:0]            m_tuser,
   output logic [CHANNELS*32-1:0]         peer_ip,
   output logic [CHANNELS*16-1:0]         peer_port,
   output logic [CHANNELS-1:0]            peer_valid,
   output logic [CHANNELS*CNT_WIDTH-1:0]  frame_count,
   output logic [CHANNELS*CNT_WIDTH-1:0]  bad_count,
   output logic [CNT_WIDTH-1:0]           drop_count
);

   localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      FWD,
      DROP
   } state_t;

   state_t                 state_q;
   logic [SELW-1:0]        sel_q;
   logic [31:0]            ip_q;
   logic [15:0]            port_q;
   logic [CNT_WIDTH-1:0]   frame_q [CHANNELS];
   logic [CNT_WIDTH-1:0]   bad_q   [CHANNELS];
   logic [CNT_WIDTH-1:0]   drop_q;
   logic [31:0]            pip_q   [CHANNELS];
   logic [15:0]            pport_q [CHANNELS];
   logic [CHANNELS-1:0]    pval_q;

   logic [16:0]            off_d;
   logic                   hit_d;
   logic [SELW-1:0]        sel_d;
   logic                   sel_rdy_d;
   logic                   beat_d;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(
      input logic [CNT_WIDTH-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

   // 17-bit offset: ports below BASE_PORT land in the upper half
   // and never compare equal to a channel index.
   always_comb begin
      off_d = {1'b0, s_udp_dest_port} - {1'b0, BASE_PORT};
      hit_d = 1'b0;
      sel_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (off_d == 17'(i)) begin
            hit_d = chan_enable[i];
            sel_d = SELW'(i);
         end
      end
   end

   always_comb begin
      sel_rdy_d = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel_q == SELW'(i)) begin
            sel_rdy_d = m_tready[i];
         end
      end
   end

   // Outputs are gated by rst so they hold their reset values
   // while reset is asserted, before the first clock edge.
   always_comb begin
      s_udp_hdr_ready = !rst || (state_q == IDLE);
      s_udp_payload_axis_tready = 1'b0;
      if (rst) begin
         unique case (state_q)
            FWD:     s_udp_payload_axis_tready = sel_rdy_d;
            DROP:    s_udp_payload_axis_tready = 1'b1;
            default: s_udp_payload_axis_tready = 1'b0;
         endcase
      end
   end

   always_comb begin
      m_tvalid = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         m_tvalid[i] = rst && (state_q == FWD) &&
                       (sel_q == SELW'(i)) &&
                       s_udp_payload_axis_tvalid;
      end
   end

   assign beat_d = s_udp_payload_axis_tvalid &&
                   s_udp_payload_axis_tready;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      assign m_tdata[g*DATA_WIDTH +: DATA_WIDTH] =
         s_udp_payload_axis_tdata;
      assign m_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH] =
         s_udp_payload_axis_tkeep;
      assign m_tlast[g] = s_udp_payload_axis_tlast;
      assign m_tuser[g] = s_udp_payload_axis_tuser;
      assign peer_ip[g*32 +: 32]   = pip_q[g];
      assign peer_port[g*16 +: 16] = pport_q[g];
      assign frame_count[g*CNT_WIDTH +: CNT_WIDTH] = frame_q[g];
      assign bad_count[g*CNT_WIDTH +: CNT_WIDTH]   = bad_q[g];
   end

   assign peer_valid = pval_q;
   assign drop_count = drop_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ip_q    <= '0;
         port_q  <= '0;
         drop_q  <= '0;
         pval_q  <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            frame_q[i] <= '0;
            bad_q[i]   <= '0;
            pip_q[i]   <= '0;
            pport_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (s_udp_hdr_valid) begin
                  sel_q   <= sel_d;
                  ip_q    <= s_udp_ip_source_ip;
                  port_q  <= s_udp_source_port;
                  state_q <= hit_d ? FWD : DROP;
               end
            end
            FWD: begin
               if (beat_d && s_udp_payload_axis_tlast) begin
                  state_q <= IDLE;
                  for (int i = 0; i < CHANNELS; i++) begin
                     if (sel_q == SELW'(i)) begin
                        if (s_udp_payload_axis_tuser) begin
                           bad_q[i] <= sat_inc(bad_q[i]);
                        end else begin
                           frame_q[i] <= sat_inc(frame_q[i]);
                           pip_q[i]   <= ip_q;
                           pport_q[i] <= port_q;
                           pval_q[i]  <= 1'b1;
                        end
                     end
                  end
               end
            end
            DROP: begin
               if (beat_d && s_udp_payload_axis_tlast) begin
                  drop_q  <= sat_inc(drop_q);
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_port_demux.sv
// tb_udp_port_demux: randomized self-checking bench for
// udp_port_demux against a frame-level reference model.
module tb_udp_port_demux;

   localparam int CH   = 4;
   localparam int DW   = 8;
   localparam int KW   = 1;
   localparam int CW   = 4;
   localparam int BASE = 1234;
   localparam int CMAX = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [CH-1:0]    chan_enable;
   logic             hdr_valid;
   logic             hdr_ready;
   logic [31:0]      src_ip;
   logic [15:0]      src_port;
   logic [15:0]      dst_port;
   logic [DW-1:0]    tdata;
   logic [KW-1:0]    tkeep;
   logic             tvalid;
   logic             tready;
   logic             tlast;
   logic             tuser;
   logic [CH*DW-1:0] m_tdata;
   logic [CH*KW-1:0] m_tkeep;
   logic [CH-1:0]    m_tvalid;
   logic [CH-1:0]    m_tready;
   logic [CH-1:0]    m_tlast;
   logic [CH-1:0]    m_tuser;
   logic [CH*32-1:0] peer_ip;
   logic [CH*16-1:0] peer_port;
   logic [CH-1:0]    peer_valid;
   logic [CH*CW-1:0] frame_count;
   logic [CH*CW-1:0] bad_count;
   logic [CW-1:0]    drop_count;

   always #5 clk = ~clk;

   udp_port_demux #(
      .CHANNELS   (CH),
      .DATA_WIDTH (DW),
      .KEEP_WIDTH (KW),
      .BASE_PORT  (16'd1234),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .chan_enable               (chan_enable),
      .s_udp_hdr_valid           (hdr_valid),
      .s_udp_hdr_ready           (hdr_ready),
      .s_udp_ip_source_ip        (src_ip),
      .s_udp_source_port         (src_port),
      .s_udp_dest_port           (dst_port),
      .s_udp_payload_axis_tdata  (tdata),
      .s_udp_payload_axis_tkeep  (tkeep),
      .s_udp_payload_axis_tvalid (tvalid),
      .s_udp_payload_axis_tready (tready),
      .s_udp_payload_axis_tlast  (tlast),
      .s_udp_payload_axis_tuser  (tuser),
      .m_tdata                   (m_tdata),
      .m_tkeep                   (m_tkeep),
      .m_tvalid                  (m_tvalid),
      .m_tready                  (m_tready),
      .m_tlast                   (m_tlast),
      .m_tuser                   (m_tuser),
      .peer_ip                   (peer_ip),
      .peer_port                 (peer_port),
      .peer_valid                (peer_valid),
      .frame_count               (frame_count),
      .bad_count                 (bad_count),
      .drop_count                (drop_count)
   );

   int errors = 0;
   int checks = 0;

   int          m_frame [CH];
   int          m_bad   [CH];
   int          m_drop;
   logic [31:0] m_ip    [CH];
   logic [15:0] m_port  [CH];
   logic [CH-1:0] m_pval;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_frame[i] = 0;
         m_bad[i]   = 0;
         m_ip[i]    = '0;
         m_port[i]  = '0;
      end
      m_drop = 0;
      m_pval = '0;
   endtask

   task automatic check_stats(input string tag);
      for (int i = 0; i < CH; i++) begin
         chk({tag, "_frame"}, 64'(frame_count[i*CW +: CW]),
             64'(m_frame[i]));
         chk({tag, "_bad"}, 64'(bad_count[i*CW +: CW]),
             64'(m_bad[i]));
         chk({tag, "_pip"}, 64'(peer_ip[i*32 +: 32]), 64'(m_ip[i]));
         chk({tag, "_pport"}, 64'(peer_port[i*16 +: 16]),
             64'(m_port[i]));
      end
      chk({tag, "_pval"}, 64'(peer_valid), 64'(m_pval));
      chk({tag, "_drop"}, 64'(drop_count), 64'(m_drop));
   endtask

   // Caller is at a falling edge.
   task automatic do_reset(input int cycles);
      rst       = 1'b0;
      hdr_valid = 1'b0;
      tvalid    = 1'b0;
      repeat (cycles) @(negedge clk);
      #1;
      chk("rst_hdr_ready", 64'(hdr_ready), 64'd1);
      chk("rst_tready", 64'(tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      #1;
      chk("post_rst_hdr_ready", 64'(hdr_ready), 64'd1);
      chk("post_rst_tready", 64'(tready), 64'd0);
   endtask

   // rmode: 0 all ready, 1 ready pattern 1,0,0,1 on the target
   // lane, 2 random ready and random source valid.
   // Caller is at a falling edge; returns at a falling edge.
   task automatic send_frame(input logic [15:0] dest,
                             input logic [31:0] ip,
                             input logic [15:0] sp,
                             input int nb,
                             input bit bad,
                             input int rmode,
                             input int abort_at,
                             input bit scramble);
      int            off;
      bit            route;
      int            ch;
      int            b;
      int            cyc;
      bit            acc;
      bit            exp_rdy;
      logic [CH-1:0] exp_mv;
      logic [CH-1:0] en_s;
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [3:0]    pat;
      pat = 4'b1001;
      hdr_valid = 1'b1;
      dst_port  = dest;
      src_ip    = ip;
      src_port  = sp;
      tvalid    = 1'b1;
      tlast     = 1'b1;
      tuser     = 1'b0;
      m_tready  = CH'($urandom);
      #1;
      chk("hdr_ready", 64'(hdr_ready), 64'd1);
      chk("idle_tready", 64'(tready), 64'd0);
      chk("idle_m_tvalid", 64'(m_tvalid), 64'd0);
      en_s  = chan_enable;
      off   = int'(dest) - BASE;
      route = 1'b0;
      ch    = 0;
      if (off >= 0 && off < CH) begin
         route = en_s[off];
         ch    = off;
      end
      @(negedge clk);
      hdr_valid = 1'b0;
      dst_port  = 16'(BASE + 1);
      src_ip    = $urandom;
      src_port  = 16'($urandom);
      b   = 0;
      cyc = 0;
      while (b < nb && cyc < 64) begin
         if (b == abort_at) begin
            rst    = 1'b0;
            tvalid = 1'b1;
            tlast  = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("abort_stall_tready", 64'(tready), 64'd0);
            chk("abort_m_tvalid", 64'(m_tvalid), 64'd0);
            tvalid = 1'b0;
            model_reset();
            @(negedge clk);
            return;
         end
         d     = DW'($urandom);
         k     = KW'($urandom);
         tdata = d;
         tkeep = k;
         tlast = (b == nb - 1);
         tuser = tlast ? bad : 1'($urandom);
         tvalid = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         unique case (rmode)
            0: m_tready = '1;
            1: begin
               m_tready     = CH'($urandom);
               m_tready[ch] = pat[3 - (cyc % 4)];
            end
            default: m_tready = CH'($urandom);
         endcase
         if (scramble && b == 1) chan_enable = CH'($urandom);
         #1;
         exp_rdy = route ? m_tready[ch] : 1'b1;
         exp_mv  = '0;
         if (route && tvalid) exp_mv[ch] = 1'b1;
         chk("tready", 64'(tready), 64'(exp_rdy));
         chk("m_tvalid", 64'(m_tvalid), 64'(exp_mv));
         if (route && tvalid) begin
            chk("m_tdata", 64'(m_tdata[ch*DW +: DW]), 64'(d));
            chk("m_tkeep", 64'(m_tkeep[ch*KW +: KW]), 64'(k));
            chk("m_tlast", 64'(m_tlast[ch]), 64'(tlast));
            chk("m_tuser", 64'(m_tuser[ch]), 64'(tuser));
         end
         acc = tvalid && exp_rdy;
         @(negedge clk);
         if (acc) b++;
         cyc++;
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
      if (b < nb) chk("frame_timeout", 64'(b), 64'(nb));
      if (route) begin
         if (bad) begin
            m_bad[ch] = sat(m_bad[ch]);
         end else begin
            m_frame[ch] = sat(m_frame[ch]);
            m_ip[ch]    = ip;
            m_port[ch]  = sp;
            m_pval[ch]  = 1'b1;
         end
      end else begin
         m_drop = sat(m_drop);
      end
   endtask

   initial begin
      logic [15:0] dp;
      chan_enable = '1;
      hdr_valid   = 1'b0;
      src_ip      = '0;
      src_port    = '0;
      dst_port    = '0;
      tdata       = '0;
      tkeep       = '0;
      tvalid      = 1'b0;
      tlast       = 1'b0;
      tuser       = 1'b0;
      m_tready    = '0;
      model_reset();
      @(negedge clk);
      do_reset(3);
      check_stats("reset");

      send_frame(16'd1236, 32'h0A000005, 16'd5000, 4, 0, 0, -1, 0);
      check_stats("ch2");
      chk("ch2_pval", 64'(peer_valid), 64'b0100);

      send_frame(16'd1233, 32'h01020304, 16'd1, 2, 0, 0, -1, 0);
      send_frame(16'd1238, 32'h01020305, 16'd2, 3, 0, 2, -1, 0);
      send_frame(16'hFFFF, 32'h01020306, 16'd3, 1, 0, 0, -1, 0);
      chan_enable = 4'b1101;
      send_frame(16'd1235, 32'h01020307, 16'd4, 2, 0, 0, -1, 0);
      chan_enable = '1;
      check_stats("drops");
      chk("drop_total", 64'(drop_count), 64'd4);

      send_frame(16'd1234, 32'hC0A80001, 16'd7, 4, 1, 1, -1, 0);
      check_stats("ch0_bad");

      send_frame(16'd1235, 32'hC0A80002, 16'd8, 5, 0, 0, 2, 0);
      check_stats("abort");
      send_frame(16'd1237, 32'hC0A80003, 16'd9, 3, 0, 0, -1, 0);
      check_stats("ch3");

      for (int n = 0; n < 30; n++) begin
         chan_enable = CH'($urandom);
         dp = ($urandom_range(0, 7) == 0) ? 16'hFFFF :
              16'(1230 + $urandom_range(0, 9));
         send_frame(dp, $urandom, 16'($urandom),
                    $urandom_range(1, 5), 1'($urandom), 2, -1, 1);
      end
      chan_enable = '1;
      check_stats("random");

      do_reset(1);
      for (int n = 0; n < 17; n++) begin
         send_frame(16'd1234, $urandom, 16'($urandom),
                    $urandom_range(1, 3), 0, 0, -1, 0);
      end
      check_stats("sat");
      chk("sat_frame0", 64'(frame_count[0 +: CW]), 64'(CMAX));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
